// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the comparator response checker.
// Provides the FSM state enum, default widths and the sweep length helper.
package cmp_pkg;

  localparam int CMP_WIDTH = 8;
  localparam int CMP_ERR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned sweep_len(
    input int unsigned width
  );
    return 32'd1 << (2 * width);
  endfunction

endpackage

// File: rtl/cmp_checker_if.sv
// cmp_checker_if: beat stream from the comparator under test to the checker.
// Ports: in_valid/in_ready handshake, operands a/b, DUT greater/less results.
interface cmp_checker_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             greater;
  logic             less;

  modport master (
    output in_valid,
    output a,
    output b,
    output greater,
    output less,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  greater,
    input  less,
    output in_ready
  );

endinterface

// File: rtl/cmp_ref.sv
// cmp_ref: combinational reference unsigned magnitude compare.
// Ports: a, b operands in; greater_exp (a>b), less_exp (a<b) out.
module cmp_ref #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater_exp,
  output logic             less_exp
);

  assign greater_exp = a > b;
  assign less_exp    = a < b;

endmodule

// File: rtl/cmp_checker.sv
// cmp_checker: checks comparator beats, counts mismatches, logs first failure.
// Ports: clk, rst (sync high), start, bus (slave), run status. Macro: CMP_CHECK_ORDER_EN.
module cmp_checker
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int ERR_W = CMP_ERR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  cmp_checker_if.slave       bus,
  output logic [2*WIDTH:0]   vec_count,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic               done,
  output logic               pass
);

  localparam int VW = 2 * WIDTH + 1;
  localparam logic [VW-1:0] LAST = VW'(sweep_len(WIDTH) - 1);

  state_t           state;
  logic             ready_q;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_g;
  logic             s1_l;
  logic             s1_ord;

  logic             accept;
  logic             ord_bad;
  logic             gt_exp;
  logic             lt_exp;
  logic             mismatch;
  logic             err_inc;
  logic [ERR_W-1:0] err_next;

  assign bus.in_ready = ready_q;
  assign accept       = bus.in_valid && ready_q;

`ifdef CMP_CHECK_ORDER_EN
  // Sweep order is judged at acceptance, against the pre-increment count.
  assign ord_bad = {bus.a, bus.b} != vec_count[2*WIDTH-1:0];
`else
  assign ord_bad = 1'b0;
`endif

  cmp_ref #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a          (s1_a),
    .b          (s1_b),
    .greater_exp(gt_exp),
    .less_exp   (lt_exp)
  );

  // greater&&less never matches the reference, so it needs no special case.
  assign mismatch = s1_valid &&
                    (s1_g != gt_exp || s1_l != lt_exp || s1_ord);
  assign err_inc  = mismatch && (err_count != '1);
  assign err_next = err_count + ERR_W'(err_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ready_q         <= 1'b0;
      s1_valid        <= 1'b0;
      s1_a            <= '0;
      s1_b            <= '0;
      s1_g            <= 1'b0;
      s1_l            <= 1'b0;
      s1_ord          <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (start) begin
      // Restart from any state; a beat still in the check stage is dropped.
      state           <= RUN;
      ready_q         <= 1'b1;
      s1_valid        <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      s1_valid  <= 1'b0;
      err_count <= err_next;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_a     <= s1_a;
        first_err_b     <= s1_b;
      end
      unique case (state)
        IDLE, DONE: ;
        RUN: begin
          if (accept) begin
            s1_valid  <= 1'b1;
            s1_a      <= bus.a;
            s1_b      <= bus.b;
            s1_g      <= bus.greater;
            s1_l      <= bus.less;
            s1_ord    <= ord_bad;
            vec_count <= vec_count + 1'b1;
            if (vec_count == LAST) begin
              state   <= DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Last beat retires this cycle, so judge pass on err_next.
          state <= DONE;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_checker.sv
// tb_cmp_checker: directed, table-driven bench for cmp_checker.
// Uses a 4-bit operand build so full sweeps stay short; 2-bit error counter.
module tb_cmp_checker;

  localparam int W  = 4;
  localparam int EW = 2;
  localparam int N  = 1 << (2 * W);

`ifdef CMP_CHECK_ORDER_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2*W:0]  vec_count;
  logic [EW-1:0] err_count;
  logic          first_err_valid;
  logic [W-1:0]  first_err_a;
  logic [W-1:0]  first_err_b;
  logic          done;
  logic          pass;

  int n_chk  = 0;
  int n_fail = 0;

  cmp_checker_if #(.WIDTH(W)) bus ();

  cmp_checker #(
    .WIDTH(W),
    .ERR_W(EW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bus            (bus),
    .vec_count      (vec_count),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_a    (first_err_a),
    .first_err_b    (first_err_b),
    .done           (done),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         g;
    logic         l;
    bit           bad;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic g, input logic l);
    bus.a        = a;
    bus.b        = b;
    bus.greater  = g;
    bus.less     = l;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst vec_count", vec_count, 0);
    chk("rst err_count", err_count, 0);
    chk("rst first_err_valid", first_err_valid, 0);
    chk("rst first_err_a", first_err_a, 0);
    chk("rst first_err_b", first_err_b, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
  endtask

  task automatic sweep(input bit fault, input bit swap, input bit gaps);
    for (int i = 0; i < N; i++) begin
      int k;
      logic [2*W-1:0] ab;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic g;
      k = i;
      if (swap && i == 2) k = 3;
      else if (swap && i == 3) k = 2;
      ab = k[2*W-1:0];
      a  = ab[2*W-1:W];
      b  = ab[W-1:0];
      g  = a > b;
      if (fault && a == 4'h5 && b == 4'h3) g = 1'b0;
      if (gaps && i > 0) begin
        bus.in_valid = 1'b0;
        step();
        if (i == 128) chk("gap vec_count", vec_count, 128);
      end
      beat(a, b, g, a < b);
    end
  endtask

  task automatic finish_run(input string tag, input int e_err,
                            input bit e_fev, input int e_fa,
                            input int e_fb);
    chk({tag, " drain in_ready"}, bus.in_ready, 0);
    chk({tag, " drain done"}, done, 0);
    step();
    chk({tag, " done"}, done, 1);
    chk({tag, " pass"}, pass, e_err == 0);
    chk({tag, " vec_count"}, vec_count, N);
    chk({tag, " err_count"}, err_count, e_err);
    chk({tag, " first_err_valid"}, first_err_valid, e_fev);
    chk({tag, " first_err_a"}, first_err_a, e_fa);
    chk({tag, " first_err_b"}, first_err_b, e_fb);
  endtask

  initial begin
    int e_err;
    bit e_fev;
    int e_fa;
    int e_fb;

    tbl[0] = '{4'h3, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'h1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'h7, 4'h7, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'hA, 4'hA, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{4'h0, 4'hF, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{4'h8, 4'h7, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'h2, 4'h9, 1'b1, 1'b0, 1'b1};

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.greater  = 1'b0;
    bus.less     = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset();

    beat(4'h1, 4'h2, 1'b0, 1'b1);
    step();
    chk("idle beat ignored", vec_count, 0);

    pulse_start();
    chk("start in_ready", bus.in_ready, 1);

    e_err = 0;
    e_fev = 0;
    e_fa  = 0;
    e_fb  = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] idx;
      bit bad;
      idx = i[7:0];
      bad = tbl[i].bad || (ORD && {tbl[i].a, tbl[i].b} != idx);
      beat(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].l);
      chk($sformatf("tbl%0d vec_count", i), vec_count, i + 1);
      chk($sformatf("tbl%0d err_lat", i), err_count, e_err);
      if (bad) begin
        if (e_err < 3) e_err++;
        if (!e_fev) begin
          e_fev = 1;
          e_fa  = tbl[i].a;
          e_fb  = tbl[i].b;
        end
      end
      step();
      chk($sformatf("tbl%0d err_count", i), err_count, e_err);
      chk($sformatf("tbl%0d first_err_valid", i), first_err_valid, e_fev);
      chk($sformatf("tbl%0d first_err_a", i), first_err_a, e_fa);
      chk($sformatf("tbl%0d first_err_b", i), first_err_b, e_fb);
    end

    beat(4'hA, 4'hA, 1'b1, 1'b1);
    pulse_start();
    chk("restart vec_count", vec_count, 0);
    chk("restart err_count", err_count, 0);
    step();
    chk("restart discard err", err_count, 0);
    chk("restart discard fev", first_err_valid, 0);
    chk("restart in_ready", bus.in_ready, 1);

    sweep(1'b0, 1'b0, 1'b0);
    finish_run("clean", 0, 0, 0, 0);

    beat(4'h1, 4'h2, 1'b1, 1'b1);
    step();
    chk("done beat vec_count", vec_count, N);
    chk("done beat err_count", err_count, 0);
    chk("done held", done, 1);

    pulse_start();
    chk("start clears done", done, 0);
    sweep(1'b1, 1'b0, 1'b0);
    finish_run("fault", 1, 1, 5, 3);

    pulse_start();
    sweep(1'b0, 1'b0, 1'b1);
    finish_run("gaps", 0, 0, 0, 0);

    pulse_start();
    for (int i = 0; i < 100; i++) begin
      logic [2*W-1:0] ab;
      ab = i[2*W-1:0];
      beat(ab[2*W-1:W], ab[W-1:0], ab[2*W-1:W] > ab[W-1:0],
           ab[2*W-1:W] < ab[W-1:0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset();
    pulse_start();
    sweep(1'b0, 1'b0, 1'b0);
    finish_run("post-rst", 0, 0, 0, 0);

    pulse_start();
    sweep(1'b0, 1'b1, 1'b0);
    if (ORD) finish_run("swap", 2, 1, 0, 3);
    else finish_run("swap", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
